// File: rtl/alu_sequencer.sv
// alu_sequencer: debounced single-key operand entry for the lab ALU.
// The user presses the key three times to load operand A, operand B and a
// 3-bit function code from the 4-bit switch nibble. The third press issues a
// req/ack request to the ALU. The result is captured for display, or 8'hFF
// with error=1 if no ack arrives within TIMEOUT_CYCLES cycles.
// Ports:
//   clock, reset    system clock (rising edge), async active-high reset
//   sw[3:0]         data nibble, sampled only on an accepted press
//   key_enter       raw push-button level, active-high, bouncy
//   result[7:0]     ALU output, valid while ack=1
//   ack             ALU response strobe, only looked at in ISSUE
//   op_a, op_b      registered operands
//   op_fn           registered function code
//   req             request strobe, high only in ISSUE
//   result_q        captured result
//   state           current state code
//   error           set when the ack wait times out
module alu_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       key_enter,
  input  logic [7:0] result,
  input  logic       ack,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [2:0] op_fn,
  output logic       req,
  output logic [7:0] result_q,
  output logic [2:0] state,
  output logic       error
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_FN = 3'd2,
    ISSUE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t cur, nxt;

  // Key input: 2-flop synchronizer, then a level debouncer. The debounced
  // level only follows the synced level after it has differed for
  // DEBOUNCE_CYCLES consecutive edges.
  logic [1:0]    sync;
  logic          db, db_d;
  logic [DW-1:0] db_cnt;
  logic          press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], key_enter};
      db_d <= db;
      if (sync[1] == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db     <= sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_d;

  // Next-state and datapath next values
  logic [3:0]    a_n, b_n;
  logic [2:0]    fn_n;
  logic          req_n, err_n;
  logic [7:0]    res_n;
  logic [TW-1:0] wcnt, wcnt_n;

  always_comb begin
    nxt    = cur;
    a_n    = op_a;
    b_n    = op_b;
    fn_n   = op_fn;
    req_n  = req;
    res_n  = result_q;
    err_n  = error;
    wcnt_n = wcnt;
    case (cur)
      LOAD_A: if (press) begin
        a_n = sw;
        nxt = LOAD_B;
      end
      LOAD_B: if (press) begin
        b_n = sw;
        nxt = LOAD_FN;
      end
      LOAD_FN: if (press) begin
        fn_n   = sw[2:0];
        req_n  = 1'b1;
        wcnt_n = '0;
        nxt    = ISSUE;
      end
      ISSUE: begin
        // ack is checked first so an ack on the timeout edge still wins
        if (ack) begin
          res_n = result;
          req_n = 1'b0;
          nxt   = DONE;
        end else if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_n = 1'b1;
          res_n = 8'hFF;
          req_n = 1'b0;
          nxt   = DONE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      DONE: if (press) begin
        err_n = 1'b0;
        nxt   = LOAD_A;
      end
      default: begin
        // Illegal codes recover to LOAD_A without leaving a request pending
        req_n = 1'b0;
        nxt   = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= LOAD_A;
    else       cur <= nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      op_fn    <= '0;
      req      <= 1'b0;
      result_q <= 8'h00;
      error    <= 1'b0;
      wcnt     <= '0;
    end else begin
      op_a     <= a_n;
      op_b     <= b_n;
      op_fn    <= fn_n;
      req      <= req_n;
      result_q <= res_n;
      error    <= err_n;
      wcnt     <= wcnt_n;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed steps plus randomized transactions,
// checked against a transaction-level model of entry/issue/timeout behaviour.
module tb_alu_sequencer;

  localparam int DEB = 4;
  localparam int TO  = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = '0;
  logic       key_enter = 1'b0;
  logic [7:0] result;
  logic       ack;
  logic [3:0] op_a, op_b;
  logic [2:0] op_fn;
  logic       req;
  logic [7:0] result_q;
  logic [2:0] state;
  logic       error;

  int tests = 0;
  int fails = 0;

  // ALU responder: ack rises once req has been seen high for more than
  // ack_delay negative edges, i.e. on ISSUE edge number ack_delay+1.
  int ack_delay = 0;
  int req_cnt   = 0;
  int req_total = 0;

  alu_sequencer #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .sw(sw), .key_enter(key_enter),
    .result(result), .ack(ack), .op_a(op_a), .op_b(op_b), .op_fn(op_fn),
    .req(req), .result_q(result_q), .state(state), .error(error)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] fn);
    case (fn)
      3'd0: return {4'h0, a & b};
      3'd1: return {4'h0, a | b};
      3'd2: return {4'h0, a ^ b};
      3'd3: return 8'(a) + 8'(b);
      3'd4: return 8'(a) - 8'(b);
      3'd5: return 8'(a) * 8'(b);
      default: return 8'h00;
    endcase
  endfunction

  assign result = alu_f(op_a, op_b, op_fn);
  assign ack    = req && (req_cnt > ack_delay);

  always @(negedge clock) begin
    req_cnt = req ? req_cnt + 1 : 0;
    if (req) req_total = req_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One clean (optionally bouncy) press and release; sw held throughout.
  task automatic press(input logic [3:0] v, input bit bounce);
    sw = v;
    @(negedge clock);
    if (bounce) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        key_enter = 1'b1; cycles($urandom_range(1, 3));
        key_enter = 1'b0; cycles($urandom_range(1, 2));
      end
    end
    key_enter = 1'b1; cycles(DEB + 10);
    key_enter = 1'b0; cycles(DEB + 10);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int n = 0;
    while (state !== s && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  // Full transaction from LOAD_A to DONE, checked against the model.
  task automatic txn(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] fsw, input int dly, input bit bounce);
    int start;
    int exp_req;
    logic [7:0] exp_res;
    logic exp_err;
    ack_delay = dly;
    press(a, bounce);
    press(b, bounce);
    start = req_total;
    press(fsw, bounce);
    wait_state({tag, "_done"}, 3'd4);
    cycles(2);
    if (dly < TO) begin
      exp_req = dly + 1; exp_res = alu_f(a, b, fsw[2:0]); exp_err = 1'b0;
    end else begin
      exp_req = TO; exp_res = 8'hFF; exp_err = 1'b1;
    end
    chk({tag, "_op_a"},  32'(op_a), 32'(a));
    chk({tag, "_op_b"},  32'(op_b), 32'(b));
    chk({tag, "_op_fn"}, 32'(op_fn), 32'(fsw[2:0]));
    chk({tag, "_reqlen"}, 32'(req_total - start), 32'(exp_req));
    chk({tag, "_req"},   32'(req), 32'd0);
    chk({tag, "_res"},   32'(result_q), 32'(exp_res));
    chk({tag, "_err"},   32'(error), 32'(exp_err));
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_op_fn", 32'(op_fn), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_res", 32'(result_q), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Bounce: 3 high, low, 2 high -> no press
    key_enter = 1'b1; cycles(3);
    key_enter = 1'b0; cycles(1);
    key_enter = 1'b1; cycles(2);
    key_enter = 1'b0; cycles(20);
    chk("bounce_state", 32'(state), 32'd0);

    // Press latency: state changes at edge 2+DEB counted from first sampling edge
    sw = 4'd3;
    key_enter = 1'b1;
    repeat (DEB + 2) @(posedge clock);
    #1 chk("lat_before", 32'(state), 32'd0);
    @(posedge clock);
    #1 chk("lat_after", 32'(state), 32'd1);
    cycles(DEB + 6);
    key_enter = 1'b0; cycles(DEB + 10);
    reset = 1'b1; #1; reset = 1'b0;
    cycles(2);

    // Full sequence with combinational-style ack: 3 + 5 = 8
    txn("full", 4'd3, 4'd5, 4'd3, 0, 1'b0);
    press(4'd0, 1'b0);
    chk("full_back", 32'(state), 32'd0);

    // Delayed ack on 5th ISSUE edge
    txn("delay5", 4'hA, 4'h7, 4'h4, 4, 1'b0);
    press(4'd0, 1'b0);

    // Ack exactly on the timeout edge wins
    txn("edge14", 4'h6, 4'h3, 4'hD, TO - 1, 1'b0);
    press(4'd0, 1'b0);

    // Timeout, then return with operands retained
    txn("tmo", 4'h9, 4'h2, 4'h1, 1000, 1'b0);
    press(4'hC, 1'b0);
    chk("tmo_back_state", 32'(state), 32'd0);
    chk("tmo_back_err", 32'(error), 32'd0);
    chk("tmo_keep_a", 32'(op_a), 32'h9);

    // Randomized transactions
    for (int t = 0; t < 8; t++) begin
      txn($sformatf("rnd%0d", t), 4'($urandom), 4'($urandom), 4'($urandom),
          int'($urandom_range(0, 20)), 1'b1);
      press(4'($urandom), 1'b1);
      chk($sformatf("rnd%0d_back", t), 32'(state), 32'd0);
    end

    // Reset in the middle of ISSUE
    ack_delay = 1000;
    press(4'h1, 1'b0);
    press(4'h2, 1'b0);
    sw = 4'h3;
    key_enter = 1'b1;
    wait_state("mid_issue", 3'd3);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_op_a", 32'(op_a), 32'd0);
    chk("mid_rst_op_b", 32'(op_b), 32'd0);
    chk("mid_rst_res", 32'(result_q), 32'd0);
    chk("mid_rst_err", 32'(error), 32'd0);
    key_enter = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(3);

    // Held key: exactly one advance, then a second press advances again
    sw = 4'h5;
    key_enter = 1'b1; cycles(100);
    chk("hold_state", 32'(state), 32'd1);
    key_enter = 1'b0; cycles(20);
    chk("hold_rel_state", 32'(state), 32'd1);
    press(4'h6, 1'b0);
    chk("hold_second", 32'(state), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
